// File: rtl/challenge_result_buffer_if.sv
// ----------------------------------------------------------------------------
// challenge_result_buffer_if
// Bundles the upstream argument handshake, the pipeline result input and the
// buffered result output of challenge_result_buffer.
//
// Signals:
//   up_arg_vld   producer offers an argument set
//   up_arg_rdy   buffer has a free credit
//   pipe_arg_vld qualified arg_vld towards the arithmetic pipeline
//   pipe_res_vld pipeline result strobe
//   pipe_res     pipeline result word
//   res_vld      oldest buffered result is valid
//   res_rdy      consumer accepts res
//   res          oldest buffered result (show-ahead)
//   used         reserved entries (in flight + stored)
//   overflow     sticky: a result arrived while the FIFO was full
//
// Modports:
//   master  the buffer itself
//   slave   the surrounding producer / pipeline / consumer
// ----------------------------------------------------------------------------
interface challenge_result_buffer_if #(
  parameter int FLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
);
  logic            up_arg_vld;
  logic            up_arg_rdy;
  logic            pipe_arg_vld;
  logic            pipe_res_vld;
  logic [FLEN-1:0] pipe_res;
  logic            res_vld;
  logic            res_rdy;
  logic [FLEN-1:0] res;
  logic [CW-1:0]   used;
  logic            overflow;

  modport master (
    input  up_arg_vld,
    output up_arg_rdy,
    output pipe_arg_vld,
    input  pipe_res_vld,
    input  pipe_res,
    output res_vld,
    input  res_rdy,
    output res,
    output used,
    output overflow
  );

  modport slave (
    output up_arg_vld,
    input  up_arg_rdy,
    input  pipe_arg_vld,
    output pipe_res_vld,
    output pipe_res,
    input  res_vld,
    output res_rdy,
    input  res,
    input  used,
    input  overflow
  );
endinterface

// File: rtl/challenge_result_buffer.sv
// ----------------------------------------------------------------------------
// challenge_result_buffer
// Result FIFO placed behind the a**5 + 0.3*b - c pipeline. The pipeline cannot
// stall, so argument acceptance is gated by a credit counter: every accepted
// argument set reserves one FIFO slot until its result is popped. This keeps
// the FIFO from ever being asked to store more than DEPTH results.
//
// Ports:
//   clk  clock, all state on posedge
//   rst  synchronous active-high reset
//   bus  challenge_result_buffer_if.master (handshakes, result data, status)
// ----------------------------------------------------------------------------
module challenge_result_buffer #(
  parameter int FLEN  = 32,
  parameter int DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  challenge_result_buffer_if.master   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [FLEN-1:0] mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   used;
  logic            overflow;

  logic accept;
  logic pop;
  logic full;
  logic push;

  assign bus.up_arg_rdy   = (used < DEPTH_C);
  assign accept           = bus.up_arg_vld & bus.up_arg_rdy;
  assign bus.pipe_arg_vld = accept;

  assign bus.res_vld = (fifo_count != '0);
  assign bus.res     = mem[rd_ptr];
  assign pop         = bus.res_vld & bus.res_rdy;

  // A full FIFO can still take a result when a pop frees the head slot in
  // the same cycle; the write then lands on the slot being vacated.
  assign full = (fifo_count == DEPTH_C);
  assign push = bus.pipe_res_vld & (~full | pop);

  assign bus.used     = used;
  assign bus.overflow = overflow;

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      used       <= '0;
      overflow   <= 1'b0;
    end else begin
      case ({accept, pop})
        2'b10:   used <= used + CW'(1);
        2'b01:   used <= used - CW'(1);
        default: used <= used;
      endcase

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      if (bus.pipe_res_vld & full & ~pop) overflow <= 1'b1;
    end
  end

  // Result storage (data path, not reset)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.pipe_res;
  end

  // Every stored result holds a credit, and credits never exceed the FIFO.
  a_count_le_used : assert property (@(posedge clk) disable iff (rst)
    fifo_count <= used);
  a_used_le_depth : assert property (@(posedge clk) disable iff (rst)
    used <= DEPTH_C);

endmodule

// File: tb/tb_challenge_result_buffer.sv
// ----------------------------------------------------------------------------
// tb_challenge_result_buffer
// Directed bench for challenge_result_buffer: reset state, a vector table with
// the result source driven directly, a pointer-wrap push/pop sequence, then a
// 12-stage pipeline model for streaming, backpressure, random traffic and a
// forced overflow.
// ----------------------------------------------------------------------------
module tb_challenge_result_buffer;
  localparam int FLEN  = 32;
  localparam int DEPTH = 16;
  localparam int L     = 12;

  logic clk;
  logic rst;

  challenge_result_buffer_if #(.FLEN(FLEN), .DEPTH(DEPTH)) bus ();

  challenge_result_buffer #(.FLEN(FLEN), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result source: either the pipeline model or direct injection
  logic            inj_mode;
  logic            inj_vld;
  logic [31:0]     inj_dat;
  logic            pl_vld [L];
  logic [31:0]     pl_dat [L];
  int unsigned     acc_cnt;

  assign bus.pipe_res_vld = inj_mode ? inj_vld : pl_vld[L-1];
  assign bus.pipe_res     = inj_mode ? inj_dat : pl_dat[L-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < L; i++) pl_vld[i] <= 1'b0;
      acc_cnt <= 0;
    end else begin
      pl_vld[0] <= bus.pipe_arg_vld;
      pl_dat[0] <= 32'hC000_0000 | acc_cnt;
      if (bus.pipe_arg_vld) acc_cnt <= acc_cnt + 1;
      for (int i = 1; i < L; i++) begin
        pl_vld[i] <= pl_vld[i-1];
        pl_dat[i] <= pl_dat[i-1];
      end
    end
  end

  int checks;
  int errors;
  int cyc;

  // Monitor state
  logic        mon_en;
  logic        stream_chk;
  logic        prev_stall;
  logic [31:0] prev_res;
  int          pop_cnt;
  int          first_pop;
  int          last_pop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    if (rst) begin
      pop_cnt    = 0;
      prev_stall = 1'b0;
    end else if (mon_en) begin
      chk("pipe_arg_vld", 32'(bus.pipe_arg_vld), 32'(bus.up_arg_vld & bus.up_arg_rdy));
      checks++;
      if (bus.used > DEPTH) begin
        errors++;
        $display("FAIL used_bound actual=%0d required<=%0d", bus.used, DEPTH);
      end
      if (prev_stall) begin
        chk("stall_vld", 32'(bus.res_vld), 32'd1);
        chk("stall_res", bus.res, prev_res);
      end
      if (stream_chk) chk("stream_arg_rdy", 32'(bus.up_arg_rdy), 32'd1);
      if (bus.res_vld && bus.res_rdy) begin
        chk("order", bus.res, 32'hC000_0000 | pop_cnt);
        if (pop_cnt == 0) first_pop = cyc;
        last_pop = cyc;
        pop_cnt++;
      end
      prev_stall = bus.res_vld && !bus.res_rdy;
      prev_res   = bus.res;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    bus.up_arg_vld = 1'b0;
    bus.res_rdy    = 1'b0;
    inj_vld        = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    bus.up_arg_vld = 1'b0;
    bus.res_rdy    = 1'b1;
    n = 0;
    while ((bus.res_vld || bus.used != 0) && n < limit) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(n < limit), 32'd1);
  endtask

  typedef struct {
    logic        up_vld;
    logic        pvld;
    logic [31:0] pres;
    logic        rdy;
    logic        e_vld;
    logic [31:0] e_res;
    logic [4:0]  e_used;
    logic        e_ardy;
  } vec_t;

  vec_t vecs [10];

  initial begin
    checks = 0; errors = 0; cyc = 0;
    mon_en = 1'b0; stream_chk = 1'b0; prev_stall = 1'b0; prev_res = '0;
    pop_cnt = 0; first_pop = 0; last_pop = 0;
    inj_mode = 1'b1; inj_vld = 1'b0; inj_dat = '0;
    rst = 1'b1;
    bus.up_arg_vld = 1'b0;
    bus.res_rdy    = 1'b0;

    //                up pv  pres          rdy  vld res           used ardy
    vecs[0] = '{1'b1, 1'b1, 32'h4000_0000, 1'b0, 1'b1, 32'h4000_0000, 5'd1, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'h4000_0000, 5'd2, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h1111_1111, 5'd1, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 32'h2222_2222, 1'b1, 1'b1, 32'h2222_2222, 5'd1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 32'h3333_3333, 1'b1, 1'b1, 32'h3333_3333, 5'd1, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         5'd0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         5'd1, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 32'h4444_4444, 1'b0, 1'b1, 32'h4444_4444, 5'd1, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         5'd0, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         5'd0, 1'b1};

    // Reset state
    do_reset();
    chk("rst_res_vld", 32'(bus.res_vld), 32'd0);
    chk("rst_arg_rdy", 32'(bus.up_arg_rdy), 32'd1);
    chk("rst_used", 32'(bus.used), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);

    // Vector table, results injected directly alongside their accepts
    for (int i = 0; i < 10; i++) begin
      bus.up_arg_vld = vecs[i].up_vld;
      inj_vld        = vecs[i].pvld;
      inj_dat        = vecs[i].pres;
      bus.res_rdy    = vecs[i].rdy;
      tick();
      chk($sformatf("vec%0d_res_vld", i), 32'(bus.res_vld), 32'(vecs[i].e_vld));
      if (vecs[i].e_vld) chk($sformatf("vec%0d_res", i), bus.res, vecs[i].e_res);
      chk($sformatf("vec%0d_used", i), 32'(bus.used), 32'(vecs[i].e_used));
      chk($sformatf("vec%0d_arg_rdy", i), 32'(bus.up_arg_rdy), 32'(vecs[i].e_ardy));
    end

    // Simultaneous push/pop at one entry, running past the pointer wrap
    bus.up_arg_vld = 1'b1; inj_vld = 1'b1; inj_dat = 32'h5000_0000; bus.res_rdy = 1'b0;
    tick();
    chk("wrap_seed", bus.res, 32'h5000_0000);
    for (int i = 1; i <= 20; i++) begin
      inj_dat     = 32'h5000_0000 + i;
      bus.res_rdy = 1'b1;
      tick();
      chk($sformatf("wrap%0d_vld", i), 32'(bus.res_vld), 32'd1);
      chk($sformatf("wrap%0d_res", i), bus.res, 32'h5000_0000 + i);
      chk($sformatf("wrap%0d_used", i), 32'(bus.used), 32'd1);
    end
    bus.up_arg_vld = 1'b0; inj_vld = 1'b0;
    tick();
    chk("wrap_empty", 32'(bus.res_vld), 32'd0);
    chk("wrap_used0", 32'(bus.used), 32'd0);

    // Streaming through the L=12 pipeline model
    inj_mode = 1'b0;
    mon_en   = 1'b1;
    do_reset();
    bus.res_rdy    = 1'b1;
    bus.up_arg_vld = 1'b1;
    stream_chk     = 1'b1;
    begin
      int n;
      n = 0;
      while (acc_cnt < 200 && n < 300) begin
        tick();
        n++;
      end
      bus.up_arg_vld = 1'b0;
      chk("stream_accepts", acc_cnt, 32'd200);
      n = 0;
      while (pop_cnt < 200 && n < 100) begin
        tick();
        n++;
      end
    end
    stream_chk = 1'b0;
    chk("stream_pops", pop_cnt, 32'd200);
    chk("stream_no_gap", last_pop - first_pop, 32'd199);
    chk("stream_overflow", 32'(bus.overflow), 32'd0);

    // Full backpressure
    do_reset();
    bus.res_rdy    = 1'b0;
    bus.up_arg_vld = 1'b1;
    repeat (40) tick();
    chk("bp_accepts", acc_cnt, 32'd16);
    chk("bp_arg_rdy", 32'(bus.up_arg_rdy), 32'd0);
    chk("bp_used", 32'(bus.used), 32'd16);
    chk("bp_res_vld", 32'(bus.res_vld), 32'd1);
    chk("bp_res_first", bus.res, 32'hC000_0000);
    bus.res_rdy = 1'b1;
    chk("bp_rdy_before_pop", 32'(bus.up_arg_rdy), 32'd0);
    tick();
    chk("bp_rdy_after_pop", 32'(bus.up_arg_rdy), 32'd1);
    chk("bp_used_after_pop", 32'(bus.used), 32'd15);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk($sformatf("bp_refill%0d_rdy", i), 32'(bus.up_arg_rdy), 32'd1);
      chk($sformatf("bp_refill%0d_used", i), 32'(bus.used), 32'd15);
    end
    drain(80);
    chk("bp_all_out", pop_cnt, acc_cnt);

    // Random traffic
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      bus.up_arg_vld = 1'($urandom_range(0, 1));
      bus.res_rdy    = 1'($urandom_range(0, 1));
      tick();
    end
    drain(100);
    chk("rand_all_out", pop_cnt, acc_cnt);
    chk("rand_overflow", 32'(bus.overflow), 32'd0);

    // Forced overflow
    do_reset();
    bus.res_rdy    = 1'b0;
    bus.up_arg_vld = 1'b1;
    repeat (30) tick();
    bus.up_arg_vld = 1'b0;
    repeat (2) tick();
    chk("ovf_full_used", 32'(bus.used), 32'd16);
    chk("ovf_pre", 32'(bus.overflow), 32'd0);
    inj_mode = 1'b1; inj_vld = 1'b1; inj_dat = 32'hDEAD_BEEF;
    tick();
    inj_vld = 1'b0;
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    chk("ovf_head", bus.res, 32'hC000_0000);
    chk("ovf_used", 32'(bus.used), 32'd16);
    repeat (5) tick();
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    inj_mode = 1'b0;
    drain(40);
    chk("ovf_drained", pop_cnt, 32'd16);
    chk("ovf_no_extra", 32'(bus.res_vld), 32'd0);
    chk("ovf_still_set", 32'(bus.overflow), 32'd1);
    do_reset();
    chk("ovf_cleared", 32'(bus.overflow), 32'd0);
    chk("ovf_rst_used", 32'(bus.used), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/challenge_result_buffer.md
Name: challenge_result_buffer

Overview:
- Sits directly downstream of the a**5 + 0.3*b - c arithmetic pipeline.
- Captures every result the pipeline emits and presents it on an AXI-Stream-style res_vld/res_rdy output.
- Generates the upstream arg_rdy from a credit count, so a result is never lost when the consumer stalls; the pipeline itself has no stall input.
- The pipeline's arg_vld is qualified by this block. The a, b and c data buses bypass it.

Parameters:
- FLEN, 32, floating-point word width of res.
- DEPTH, 16, result FIFO entries; must be a power of two, at least 2.
- CW, $clog2(DEPTH+1), width of the credit/occupancy counters (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- up_arg_vld  input  1  producer offers a, b, c this cycle.
- up_arg_rdy  output  1  block can accept an argument set this cycle.
- pipe_arg_vld  output  1  to pipeline arg_vld; equals up_arg_vld AND up_arg_rdy (combinational).
- pipe_res_vld  input  1  pipeline res_vld.
- pipe_res  input  FLEN  pipeline res.
- res_vld  output  1  buffered result available.
- res_rdy  input  1  consumer accepts result.
- res  output  FLEN  oldest buffered result.
- used  output  CW  reserved entries: results in flight plus results stored.
- overflow  output  1  sticky error: pipe_res_vld arrived while the FIFO was full.

Behaviour:
- Reset (synchronous, rst high at a posedge):
  - Clears read/write pointers, fifo_count, used and overflow.
  - After reset: res_vld=0, res undefined (not checked while res_vld=0), up_arg_rdy=1, used=0, overflow=0.
  - rst has priority over all simultaneous events. Reset mid-operation discards stored and in-flight results.
  - The pipeline shares rst; results it emits after reset are undefined.
- Credit counter `used`:
  - +1 on an upstream accept (up_arg_vld AND up_arg_rdy).
  - -1 on an output pop (res_vld AND res_rdy).
  - Accept and pop in the same cycle: no change.
  - up_arg_rdy = (used < DEPTH). Combinational from state only; it does not wait for up_arg_vld.
  - used never exceeds DEPTH and never goes below 0.
- FIFO:
  - Push when pipe_res_vld: write pipe_res at the write pointer, fifo_count +1.
  - Pop when res_vld AND res_rdy: read pointer +1, fifo_count -1.
  - Push and pop in the same cycle are both performed; fifo_count unchanged.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Show-ahead output: res = mem[rd_ptr]; res_vld = (fifo_count != 0).
- Latency: pipe_res_vld at cycle t gives res_vld=1 with that value at cycle t+1 if the FIFO was empty. No combinational path from pipe_res to res.
- Output stability: while res_vld=1 and res_rdy=0, res and res_vld hold (AXI-S rule). This is true even when a push occurs that cycle.
- Ordering: results are emitted strictly in arrival order.
- Throughput:
  - Let L be the pipeline latency from arg_vld to res_vld.
  - With res_rdy held 1 and DEPTH >= L+2, up_arg_rdy stays 1 and one result per cycle is sustained with no bubbles.
  - A smaller DEPTH throttles arg acceptance but remains lossless.
- Overflow: pipe_res_vld with fifo_count==DEPTH and no pop in that cycle means the data is dropped and overflow is set until rst. This is unreachable while the credit rule holds; it is kept as a checker aid.
- Invariants (assert):
  - fifo_count <= used.
  - used - fifo_count equals the number of pipeline results in flight.

Test Plan:
- Reset: rst high 2 cycles -> res_vld=0, up_arg_rdy=1, used=0, overflow=0; then drive pipe_res_vld=1, pipe_res=32'h40000000 for 1 cycle -> res_vld=1, res=32'h40000000 next cycle.
- Back-to-back streaming:
  - Stimulus: model pipeline with L=12, DEPTH=16, res_rdy=1, 200 consecutive accepts.
  - Required: up_arg_rdy never 0, 200 results in order, no gaps once the stream starts, overflow=0.
- Full backpressure:
  - Stimulus: res_rdy=0, up_arg_vld=1 continuously.
  - Required: exactly 16 accepts, then up_arg_rdy=0 and used=16. Once all 16 have arrived, res stays at the first value.
  - Then raise res_rdy: 16 results drained in order, and each pop re-enables one accept the next cycle.
- Simultaneous push/pop:
  - Stimulus: fifo_count=1, pipe_res_vld=1 and res_rdy=1 in the same cycle.
  - Required: fifo_count stays 1 and res shows the new value next cycle. Repeat across the pointer wrap (more than 16 pushes).
- Random res_rdy (50%) with random up_arg_vld over 5000 cycles -> scoreboard matches, res stable while stalled, used never exceeds 16.
- Forced protocol violation: inject pipe_res_vld with fifo_count=16, res_rdy=0 -> overflow=1 and stays 1, FIFO contents unchanged; rst clears overflow.
